// File: rtl/pulse_channel_arbiter_if.sv
// Handshake bundle between the event sources / slow-domain echo and the
// pulse channel arbiter. The master modport is the arbiter's own view.
interface pulse_channel_arbiter_if #(
  parameter int REQ_NUM  = 4,
  parameter int ID_WIDTH = 2
);
  logic [REQ_NUM-1:0]  req_i;
  logic                ack_i;
  logic                pulse_o;
  logic [ID_WIDTH-1:0] id_o;
  logic [REQ_NUM-1:0]  pend_o;
  logic [REQ_NUM-1:0]  done_o;
  logic                error_o;

  modport master (
    input  req_i, ack_i,
    output pulse_o, id_o, pend_o, done_o, error_o
  );

  modport slave (
    output req_i, ack_i,
    input  pulse_o, id_o, pend_o, done_o, error_o
  );
endinterface

// File: rtl/pulse_channel_arbiter.sv
// Round-robin arbiter sharing one four-phase CDC pulse channel between
// REQ_NUM fast-domain event sources. One event is in flight at a time; the
// slow domain echoes pulse_o back on ack_i, which is resynchronised here.
//
// Optional build macro PULSE_ARB_TIMEOUT_EN: bounds each handshake phase to
// TIMEOUT_CYCLES, dropping the event and strobing error_o on expiry. Without
// it the arbiter waits for ack forever and error_o is tied low.
//
// state   | meaning
// IDLE    | channel free; grant next pending source if any
// ASSERT  | pulse_o high; wait for ack echo and minimum hold time
// RELEASE | pulse_o low; wait for ack echo to drop, then strobe done_o
module pulse_channel_arbiter #(
  parameter int REQ_NUM        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 12
) (
  input logic                    clk,
  input logic                    rst,
  pulse_channel_arbiter_if.master bus
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_NEED = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  if ((CNT_NEED - 1) > ((2 ** CNT_WIDTH) - 1) || (2 ** ID_WIDTH) < REQ_NUM) begin : g_param_check
    $error("pulse_channel_arbiter: CNT_WIDTH or ID_WIDTH too small for the parameters");
  end

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_t;

  state_t               state;
  logic                 ack_q1;
  logic                 ack_s;
  logic [REQ_NUM-1:0]   pend_q;
  logic [REQ_NUM-1:0]   done_q;
  logic [REQ_NUM-1:0]   grant_clr;
  logic [ID_WIDTH-1:0]  id_q;
  logic [ID_WIDTH-1:0]  ptr_q;
  logic [ID_WIDTH-1:0]  grant_idx;
  logic                 grant_vld;
  logic                 pulse_q;
  logic [CNT_WIDTH-1:0] hold_cnt;
  int                   cand;

`ifdef PULSE_ARB_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [CNT_WIDTH-1:0] tout_cnt;
  logic                 error_q;
`endif

  // Two-flop synchronizer for the slow-domain ack echo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q1 <= 1'b0;
      ack_s  <= 1'b0;
    end else begin
      ack_q1 <= bus.ack_i;
      ack_s  <= ack_q1;
    end
  end

  // Round-robin pick: scan offsets from farthest to nearest so the first
  // pending index after the pointer is the one left standing.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = REQ_NUM; k >= 1; k--) begin
      cand = (int'(ptr_q) + k) % REQ_NUM;
      if (pend_q[IDX_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = ID_WIDTH'(cand);
      end
    end
  end

  assign grant_clr = (state == IDLE && grant_vld) ? (REQ_NUM'(1) << grant_idx) : '0;

  // Pending flags: a new event on the grant edge survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~grant_clr) | bus.req_i;
    end
  end

  // Handshake FSM with registered channel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pulse_q  <= 1'b0;
      id_q     <= '0;
      ptr_q    <= ID_WIDTH'(REQ_NUM - 1);
      hold_cnt <= '0;
      done_q   <= '0;
`ifdef PULSE_ARB_TIMEOUT_EN
      tout_cnt <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef PULSE_ARB_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_vld) begin
            id_q     <= grant_idx;
            ptr_q    <= grant_idx;
            pulse_q  <= 1'b1;
            hold_cnt <= '0;
`ifdef PULSE_ARB_TIMEOUT_EN
            tout_cnt <= '0;
`endif
            state    <= ASSERT;
          end
        end
        ASSERT: begin
          if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;
`ifdef PULSE_ARB_TIMEOUT_EN
          if (tout_cnt != CNT_MAX) tout_cnt <= tout_cnt + 1'b1;
`endif
          if (ack_s && hold_cnt >= HOLD_LAST) begin
            pulse_q  <= 1'b0;
            hold_cnt <= '0;
`ifdef PULSE_ARB_TIMEOUT_EN
            tout_cnt <= '0;
`endif
            state    <= RELEASE;
          end
`ifdef PULSE_ARB_TIMEOUT_EN
          else if (!ack_s && tout_cnt >= TOUT_LAST) begin
            pulse_q <= 1'b0;
            error_q <= 1'b1;
            state   <= IDLE;
          end
`endif
        end
        RELEASE: begin
          if (!ack_s) begin
            done_q <= REQ_NUM'(1) << id_q;
            state  <= IDLE;
          end
`ifdef PULSE_ARB_TIMEOUT_EN
          else if (tout_cnt >= TOUT_LAST) begin
            error_q <= 1'b1;
            state   <= IDLE;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pulse_o = pulse_q;
  assign bus.id_o    = id_q;
  assign bus.pend_o  = pend_q;
  assign bus.done_o  = done_q;
`ifdef PULSE_ARB_TIMEOUT_EN
  assign bus.error_o = error_q;
`else
  assign bus.error_o = 1'b0;
`endif

endmodule
